draw_scheduler: RTL and testbench

//   Shares the single VGA adapter write port between N draw clients (game-win

---
 rtl/draw_scheduler.sv | 132 +++++++++++++
 tb/tb_draw_scheduler.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_scheduler.sv
// draw_scheduler: round-robin arbiter sharing one VGA adapter write port among N draw clients.
// Define DRAW_TIMEOUT_EN to add a per-grant busy watchdog that aborts a stalled client.
module draw_scheduler #(
  parameter int N_CLIENTS      = 4,
  parameter int ID_W           = 2,
  parameter int TIMEOUT_CYCLES = 16384
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [N_CLIENTS-1:0]     req,
  input  logic [N_CLIENTS-1:0]     done,
  input  logic [9*N_CLIENTS-1:0]   x_in,
  input  logic [8*N_CLIENTS-1:0]   y_in,
  input  logic [12*N_CLIENTS-1:0]  color_in,
  input  logic [N_CLIENTS-1:0]     we_in,
  output logic [N_CLIENTS-1:0]     enable_draw,
  output logic [N_CLIENTS-1:0]     client_abort,
  output logic [8:0]               X_out,
  output logic [7:0]               Y_out,
  output logic [11:0]              Color_out,
  output logic                     writeEn,
  output logic [ID_W-1:0]          grant_id,
  output logic                     busy,
  output logic                     timeout_err
);
  typedef enum logic [2:0] {IDLE, ARB, START, BUSY, RELEASE} state_t;
  state_t r_state;
  logic [ID_W-1:0] r_rr, w_win, w_next_rr;
  logic [8:0] w_x;
  logic [7:0] w_y;
  logic [11:0] w_c;
  logic w_we, w_done;
  always_comb begin
    w_win = '0;
    w_x = '0;
    w_y = '0;
    w_c = '0;
    w_we = 1'b0;
    w_done = 1'b0;
    // Scan the search order backwards so the first hit from r_rr is the last assignment
    for (int k = N_CLIENTS - 1; k >= 0; k--)
      if (req[(int'(r_rr) + k) % N_CLIENTS]) w_win = ID_W'((int'(r_rr) + k) % N_CLIENTS);
    for (int i = 0; i < N_CLIENTS; i++)
      if (grant_id == ID_W'(i)) begin
        w_x = x_in[9*i +: 9];
        w_y = y_in[8*i +: 8];
        w_c = color_in[12*i +: 12];
        w_we = we_in[i];
        w_done = done[i];
      end
    w_next_rr = (int'(grant_id) == N_CLIENTS - 1) ? '0 : grant_id + 1'b1;
  end
`ifdef DRAW_TIMEOUT_EN
  logic [14:0] r_cnt;
  logic [N_CLIENTS-1:0] r_abort;
  logic r_terr, w_limit;
  assign w_limit = (r_cnt + 15'd1) == 15'(TIMEOUT_CYCLES);
  assign client_abort = r_abort;
  assign timeout_err = r_terr;
`else
  assign client_abort = '0;
  assign timeout_err = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_rr <= '0;
      grant_id <= '0;
      enable_draw <= '0;
      X_out <= '0;
      Y_out <= '0;
      Color_out <= '0;
      writeEn <= 1'b0;
      busy <= 1'b0;
`ifdef DRAW_TIMEOUT_EN
      r_cnt <= '0;
      r_abort <= '0;
      r_terr <= 1'b0;
`endif
    end else begin
      enable_draw <= '0;
      writeEn <= 1'b0;
`ifdef DRAW_TIMEOUT_EN
      r_abort <= '0;
`endif
      case (r_state)
        IDLE: if (|req) begin
          r_state <= ARB;
          busy <= 1'b1;
        end
        ARB: if (|req) begin
          grant_id <= w_win;
          enable_draw <= N_CLIENTS'(1) << w_win;
          r_state <= START;
        end else begin
          r_state <= IDLE;
          busy <= 1'b0;
        end
        START: begin
          r_state <= BUSY;
`ifdef DRAW_TIMEOUT_EN
          r_cnt <= '0;
`endif
        end
        BUSY: begin
          X_out <= w_x;
          Y_out <= w_y;
          Color_out <= w_c;
          writeEn <= w_we;
          if (w_done) r_state <= RELEASE;
`ifdef DRAW_TIMEOUT_EN
          r_cnt <= r_cnt + 15'd1;
          if (!w_done && w_limit) begin
            r_abort <= N_CLIENTS'(1) << grant_id;
            r_terr <= 1'b1;
            r_state <= RELEASE;
          end
`endif
        end
        RELEASE: begin
          r_rr <= w_next_rr;
          r_state <= (|req) ? ARB : IDLE;
          busy <= |req;
        end
        default: begin
          r_state <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_draw_scheduler.sv
// tb_draw_scheduler: table-driven and scoreboard checks of draw_scheduler arbitration and pixel path.
module tb_draw_scheduler;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [3:0] req = '0, done = '0, we_in = '0;
  logic [35:0] x_in = '0;
  logic [31:0] y_in = '0;
  logic [47:0] color_in = '0;
  logic [3:0] enable_draw, client_abort;
  logic [8:0] X_out;
  logic [7:0] Y_out;
  logic [11:0] Color_out;
  logic writeEn, busy, timeout_err;
  logic [1:0] grant_id;
  int n_checks = 0, n_errors = 0;
  logic [28:0] sb[$];
  int gq[$];
  typedef struct {
    logic [8:0] x;
    logic [7:0] y;
    logic [11:0] c;
    logic we;
    logic [3:0] dn;
  } vec_t;
  vec_t tbl[6];

  draw_scheduler #(.N_CLIENTS(4), .ID_W(2), .TIMEOUT_CYCLES(32)) dut (
    .clk(clk), .resetn(resetn), .req(req), .done(done), .x_in(x_in), .y_in(y_in),
    .color_in(color_in), .we_in(we_in), .enable_draw(enable_draw), .client_abort(client_abort),
    .X_out(X_out), .Y_out(Y_out), .Color_out(Color_out), .writeEn(writeEn),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic do_reset;
    resetn = 1'b0;
    req = '0;
    done = '0;
    we_in = '0;
    tick;
    tick;
    resetn = 1'b1;
  endtask

  task automatic wait_en(input int lim, output int cyc);
    cyc = 0;
    while (enable_draw == 0 && cyc < lim) begin
      tick;
      cyc++;
    end
    if (enable_draw == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_en: no enable_draw within %0d cycles", lim);
    end
  endtask

  task automatic mon_pixel(inout int pulses);
    logic [28:0] e;
    if (writeEn) begin
      pulses++;
      if (sb.size() == 0) chk("pixel unexpected write", {X_out, Y_out, Color_out}, 29'h1FFFFFFF);
      else begin
        e = sb.pop_front();
        chk("pixel", {X_out, Y_out, Color_out}, e);
      end
    end
  endtask

  initial begin
    int cyc, g, ab_cyc, pulses;
    logic [3:0] ab;
    tbl[0] = '{9'd128, 8'd88, 12'hF00, 1'b1, 4'b0000};
    tbl[1] = '{9'd5, 8'd6, 12'h0AB, 1'b0, 4'b0000};
    tbl[2] = '{9'd511, 8'd255, 12'hFFF, 1'b1, 4'b0000};
    tbl[3] = '{9'd0, 8'd0, 12'h000, 1'b1, 4'b0010};
    tbl[4] = '{9'd200, 8'd100, 12'h0F0, 1'b1, 4'b1011};
    tbl[5] = '{9'd129, 8'd89, 12'h00F, 1'b1, 4'b0100};

    // reset with all clients requesting
    resetn = 1'b0;
    req = 4'hF;
    tick;
    tick;
    chk("rst enable_draw", enable_draw, 0);
    chk("rst writeEn", writeEn, 0);
    chk("rst X_out", X_out, 0);
    chk("rst Y_out", Y_out, 0);
    chk("rst Color_out", Color_out, 0);
    chk("rst busy", busy, 0);
    chk("rst grant_id", grant_id, 0);
    chk("rst client_abort", client_abort, 0);
    chk("rst timeout_err", timeout_err, 0);
    resetn = 1'b1;
    wait_en(5, cyc);
    chk("rst first grant", enable_draw, 4'b0001);
    chk("rst grant latency", (cyc >= 2 && cyc <= 3) ? 1 : 0, 1);
    tick;
    chk("rst pulse width", enable_draw, 0);

    // round robin over clients 0,1,3
    do_reset;
    req = 4'b1011;
    gq = '{0, 1, 3, 0, 1, 3};
    for (int k = 0; k < 6; k++) begin
      wait_en(12, cyc);
      g = gq.pop_front();
      chk("rr enable_draw", enable_draw, 4'(1) << g);
      chk("rr grant_id", grant_id, g);
      if (k > 0) chk("rr grant gap", cyc + 1, 3);
      tick;
      chk("rr pulse width", enable_draw, 0);
      repeat (9) tick;
      done = 4'(1) << g;
      tick;
      done = '0;
    end

    // table-driven mux: client 2 granted, other clients write garbage
    do_reset;
    x_in = 36'hA5A5A5A5A;
    y_in = 32'h5A5A5A5A;
    color_in = 48'h123456789ABC;
    we_in = 4'b1011;
    req = 4'b0100;
    wait_en(5, cyc);
    chk("mux grant", enable_draw, 4'b0100);
    req = '0;
    tick;
    chk("mux first busy writeEn", writeEn, 0);
    for (int i = 0; i < 6; i++) begin
      x_in[18 +: 9] = tbl[i].x;
      y_in[16 +: 8] = tbl[i].y;
      color_in[24 +: 12] = tbl[i].c;
      we_in = {1'b1, tbl[i].we, 2'b11};
      done = tbl[i].dn;
      if (tbl[i].we) sb.push_back({tbl[i].x, tbl[i].y, tbl[i].c});
      tick;
      done = '0;
      chk("mux writeEn", writeEn, tbl[i].we);
      chk("mux busy", busy, 1);
      chk("mux grant_id", grant_id, 2);
      pulses = 0;
      mon_pixel(pulses);
    end
    we_in = '0;
    tick;
    chk("mux writeEn after release", writeEn, 0);
    chk("mux busy after release", busy, 0);
    chk("mux scoreboard empty", sb.size(), 0);

    // foreign done ignored, then reset mid-BUSY
    do_reset;
    x_in[27 +: 9] = 9'd300;
    we_in = 4'b1000;
    req = 4'b1000;
    wait_en(5, cyc);
    chk("b4 grant", enable_draw, 4'b1000);
    tick;
    done = 4'b0010;
    tick;
    done = '0;
    repeat (3) tick;
    chk("b4 busy kept", busy, 1);
    chk("b4 grant kept", grant_id, 3);
    chk("b4 writeEn", writeEn, 1);
    chk("b4 no new grant", enable_draw, 0);
    resetn = 1'b0;
    tick;
    chk("b4 rst writeEn", writeEn, 0);
    chk("b4 rst busy", busy, 0);
    chk("b4 rst grant_id", grant_id, 0);
    chk("b4 rst X_out", X_out, 0);
    resetn = 1'b1;
    req = '0;
    we_in = '0;
    tick;
    tick;
    chk("b4 idle after rst", busy, 0);

    // stalled client: watchdog build aborts it, default build waits
    do_reset;
    req = 4'b0110;
    wait_en(5, cyc);
    chk("to grant", enable_draw, 4'b0010);
    req = 4'b0100;
    ab_cyc = -1;
    ab = '0;
    for (int i = 1; i <= 60 && ab_cyc < 0; i++) begin
      tick;
      if (client_abort != 0) begin
        ab_cyc = i;
        ab = client_abort;
      end
    end
`ifdef DRAW_TIMEOUT_EN
    chk("to abort cycle", ab_cyc, 33);
    chk("to abort vector", ab, 4'b0010);
    tick;
    chk("to abort width", client_abort, 0);
    chk("to timeout_err", timeout_err, 1);
    wait_en(5, cyc);
    chk("to next grant", enable_draw, 4'b0100);
    done = 4'b0100;
    tick;
    done = '0;
    chk("to err sticky", timeout_err, 1);
`else
    chk("to no abort", ab_cyc, -1);
    chk("to still busy", busy, 1);
    chk("to grant held", grant_id, 1);
    chk("to timeout_err", timeout_err, 0);
`endif

    // full 64x64 frame through client 0
    do_reset;
    req = 4'b0001;
    wait_en(5, cyc);
    chk("frame grant", enable_draw, 4'b0001);
    req = '0;
    tick;
    pulses = 0;
    for (int p = 0; p < 4096; p++) begin
      x_in[8:0] = 9'(128 + p % 64);
      y_in[7:0] = 8'(88 + p / 64);
      color_in[11:0] = 12'(p);
      we_in = 4'b0001;
      sb.push_back({9'(128 + p % 64), 8'(88 + p / 64), 12'(p)});
      if (p == 4095) done = 4'b0001;
      tick;
      mon_pixel(pulses);
    end
    done = '0;
    we_in = '0;
    chk("frame busy in release", busy, 1);
    tick;
    mon_pixel(pulses);
    chk("frame busy falls", busy, 0);
    chk("frame pulses", pulses, 4096);
    chk("frame scoreboard empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
